feature_buffer_reader: RTL and testbench



---
 rtl/feature_buffer_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_feature_buffer_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_buffer_reader.sv
// feature_buffer_reader: read-side client of the ping/pong feature buffer.
// Walks a 2-D region (row_len words x num_rows rows, row_stride apart),
// issues single-lane reads under credit control, collects the returned words
// in a local FIFO and streams them out in order on a valid/ready interface.
// Optional: define FEATURE_BUFFER_READER_STALL_CNT_EN to add the stall_cycles
// output (issue-credit stalls plus downstream back-pressure cycles).
module feature_buffer_reader #(
  parameter int ADDR_W     = 16,
  parameter int WIDTH      = 128,
  parameter int LEN_W      = 16,
  parameter int BUF_LAT    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  row_len,
  input  logic [LEN_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic              bank_sel,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_bank_rd_sel,
  input  logic [WIDTH-1:0]  buf_rd_data,
  input  logic              buf_rd_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
`ifdef FEATURE_BUFFER_READER_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              m_last
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TOT_W  = 2 * LEN_W;
  localparam int DROP_W = $clog2(BUF_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_row_base, r_stride;
  logic [LEN_W-1:0]   r_col, r_row_len;
  logic               r_bank, r_zero;
  logic [TOT_W-1:0]   r_total, r_issued, r_out_cnt;
  logic [CNT_W-1:0]   r_inflight, r_fifo_cnt;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic               r_err_ovf;
  logic [DROP_W-1:0]  r_drop;

  logic [TOT_W-1:0]   w_total_in;
  logic [CNT_W:0]     w_occupied;
  logic               w_credit_ok, w_rd_en, w_issue_last, w_col_last;
  logic               w_ret, w_ret_dec, w_full, w_m_valid, w_pop, w_push;
  logic               w_out_last, w_launch;

  assign w_total_in   = {{LEN_W{1'b0}}, row_len} * {{LEN_W{1'b0}}, num_rows};
  assign w_launch     = (r_state == S_IDLE) && start;
  // Credit = FIFO_DEPTH - fifo_count - inflight; a slot is reserved per read.
  assign w_occupied   = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
  assign w_credit_ok  = w_occupied < (CNT_W + 1)'(FIFO_DEPTH);
  // Gated by rst so no read escapes during the reset cycle itself.
  assign w_rd_en      = (r_state == S_ISSUE) && w_credit_ok && !rst;
  assign w_issue_last = (r_issued == r_total - TOT_W'(1));
  assign w_col_last   = (r_col == r_row_len - LEN_W'(1));
  // Returns inside the post-reset drop window belong to an abandoned job.
  assign w_ret        = buf_rd_valid && (r_drop == '0);
  assign w_ret_dec    = w_ret && (r_inflight != '0);
  assign w_full       = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign w_m_valid    = (r_fifo_cnt != '0);
  assign w_pop        = w_m_valid && m_ready;
  assign w_push       = w_ret && (!w_full || w_pop);
  assign w_out_last   = (r_out_cnt == r_total - TOT_W'(1));

  assign buf_rd_en       = w_rd_en;
  assign buf_rd_addr     = r_row_base + ADDR_W'(r_col);
  assign buf_bank_rd_sel = r_bank;
  assign m_valid         = w_m_valid;
  assign m_data          = r_mem[r_rd_ptr];
  assign m_last          = w_m_valid && w_out_last;
  assign err_ovf         = r_err_ovf;

  // FSM state register.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state and status outputs.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = (w_total_in == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (w_rd_en && w_issue_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_out_last && (r_inflight == '0)) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = r_zero;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job context: latched on launch, then address walk and word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_base <= '0;
      r_stride   <= '0;
      r_col      <= '0;
      r_row_len  <= '0;
      r_bank     <= 1'b0;
      r_zero     <= 1'b0;
      r_total    <= '0;
      r_issued   <= '0;
      r_out_cnt  <= '0;
    end else if (w_launch) begin
      r_row_base <= base_addr;
      r_stride   <= row_stride;
      r_col      <= '0;
      r_row_len  <= row_len;
      r_bank     <= bank_sel;
      r_zero     <= (w_total_in == '0);
      r_total    <= w_total_in;
      r_issued   <= '0;
      r_out_cnt  <= '0;
    end else begin
      if (w_rd_en) begin
        r_issued <= r_issued + TOT_W'(1);
        if (w_col_last) begin
          r_col      <= '0;
          r_row_base <= r_row_base + r_stride;
        end else begin
          r_col <= r_col + LEN_W'(1);
        end
      end
      if (w_pop) r_out_cnt <= r_out_cnt + TOT_W'(1);
    end
  end

  // Outstanding-read tracker; simultaneous issue and return cancel out.
  always_ff @(posedge clk) begin
    if (rst) r_inflight <= '0;
    else begin
      case ({w_rd_en, w_ret_dec})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Return FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Return FIFO storage.
  // NOTE: the data array has no reset; occupancy is tracked by the reset
  // pointers, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= buf_rd_data;
  end

  // Sticky overflow: a return arrived with the FIFO full and no pop.
  always_ff @(posedge clk) begin
    if (rst)                                    r_err_ovf <= 1'b0;
    else if (w_ret && w_full && !w_pop)         r_err_ovf <= 1'b1;
  end

  // Post-reset drop window covering reads already in the buffer pipeline.
  always_ff @(posedge clk) begin
    if (rst)                 r_drop <= DROP_W'(BUF_LAT);
    else if (r_drop != '0)   r_drop <= r_drop - DROP_W'(1);
  end

`ifdef FEATURE_BUFFER_READER_STALL_CNT_EN
  logic [31:0] r_stall;
  logic [1:0]  w_stall_inc;
  logic [32:0] w_stall_sum;

  assign w_stall_inc = {1'b0, (r_state == S_ISSUE) && !w_credit_ok}
                     + {1'b0, w_m_valid && !m_ready};
  assign w_stall_sum = {1'b0, r_stall} + 33'(w_stall_inc);
  assign stall_cycles = r_stall;

  // Saturating stall counter, cleared on each accepted launch.
  always_ff @(posedge clk) begin
    if (rst || w_launch) r_stall <= '0;
    else                 r_stall <= w_stall_sum[32] ? '1 : w_stall_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_feature_buffer_reader.sv
// Directed self-checking bench for feature_buffer_reader. Includes a
// fixed-latency buffer model (5 cycles, data derived from address) with an
// injection hook for unsolicited return words.
module tb_feature_buffer_reader;

  localparam int ADDR_W = 16;
  localparam int WIDTH  = 128;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  row_len = '0;
  logic [LEN_W-1:0]  num_rows = '0;
  logic [ADDR_W-1:0] row_stride = '0;
  logic              bank_sel = 1'b0;
  logic              busy, done, err_ovf, buf_rd_en, buf_bank_rd_sel;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [WIDTH-1:0]  buf_rd_data;
  logic              buf_rd_valid;
  logic              m_valid, m_last;
  logic              m_ready = 1'b1;
  logic [WIDTH-1:0]  m_data;
`ifdef FEATURE_BUFFER_READER_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  feature_buffer_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_len(row_len), .num_rows(num_rows), .row_stride(row_stride),
    .bank_sel(bank_sel), .busy(busy), .done(done), .err_ovf(err_ovf),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_bank_rd_sel(buf_bank_rd_sel), .buf_rd_data(buf_rd_data),
    .buf_rd_valid(buf_rd_valid), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data),
`ifdef FEATURE_BUFFER_READER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {8{a ^ 16'hC3A5}};
  endfunction

  // Buffer model: buf_rd_valid follows buf_rd_en by exactly 5 cycles.
  logic [4:0]        pv = '0;
  logic [ADDR_W-1:0] pa [5];
  logic              inj = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[3:0], buf_rd_en};
    pa[0] <= buf_rd_addr;
    for (int i = 1; i < 5; i++) pa[i] <= pa[i-1];
  end
  assign buf_rd_valid = pv[4] | inj;
  assign buf_rd_data  = inj ? {WIDTH{1'b1}} : word_of(pa[4]);

  // Monitor: samples on the falling edge, away from the active edge.
  int                cyc = 0;
  logic [ADDR_W-1:0] rd_q [$];
  int                bank_bad;
  logic [WIDTH-1:0]  dq [$];
  logic              lq [$];
  int                done_cnt, done_cyc, first_v_cyc, ret_cnt, start_cyc;
  logic              busy_at_done;
  int                n_pass = 0, n_checks = 0;

  always @(posedge clk) cyc++;

  logic              exp_bank = 1'b0;
  always @(negedge clk) begin
    if (buf_rd_en) begin
      rd_q.push_back(buf_rd_addr);
      if (buf_bank_rd_sel !== exp_bank) bank_bad++;
    end
    if (m_valid && m_ready) begin
      dq.push_back(m_data);
      lq.push_back(m_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
    if (pv[4]) ret_cnt++;
  end

  task automatic clear_logs();
    rd_q.delete(); dq.delete(); lq.delete();
    bank_bad = 0; done_cnt = 0; done_cyc = -1; first_v_cyc = -1; ret_cnt = 0;
  endtask

  task automatic start_job(input logic [15:0] b, input logic [15:0] l,
                           input logic [15:0] n, input logic [15:0] s,
                           input logic bk);
    @(posedge clk); #1;
    clear_logs();
    exp_bank = bk;
    base_addr = b; row_len = l; num_rows = n; row_stride = s; bank_sel = bk;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words(input string nm, input logic [15:0] b,
                             input int l, input int n, input logic [15:0] s);
    int idx = 0;
    logic [ADDR_W-1:0] a;
    n_checks++;
    if (rd_q.size() !== l*n || dq.size() !== l*n)
      $display("FAIL %s count: reads %0d words %0d required %0d", nm, rd_q.size(), dq.size(), l*n);
    else n_pass++;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < l; c++) begin
        a = b + ADDR_W'(r) * s + ADDR_W'(c);
        if (idx < rd_q.size()) begin
          n_checks++;
          if (rd_q[idx] !== a) $display("FAIL %s addr[%0d]: got %h required %h", nm, idx, rd_q[idx], a);
          else n_pass++;
        end
        if (idx < dq.size()) begin
          n_checks++;
          if (dq[idx] !== word_of(a) || lq[idx] !== (idx == l*n-1))
            $display("FAIL %s word[%0d]: got %h last %b required %h last %b", nm, idx, dq[idx], lq[idx], word_of(a), idx == l*n-1);
          else n_pass++;
        end
        idx++;
      end
    n_checks++;
    if (done_cnt !== 1 || bank_bad !== 0)
      $display("FAIL %s done/bank: done pulses %0d bank errors %0d required 1/0", nm, done_cnt, bank_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, err_ovf, buf_rd_en, m_valid, m_last, buf_bank_rd_sel} !== 7'b0 || buf_rd_addr !== 16'h0)
      $display("FAIL reset_state: flags %b addr %h required 0000000 0000",
               {busy, done, err_ovf, buf_rd_en, m_valid, m_last, buf_bank_rd_sel}, buf_rd_addr);
    else n_pass++;
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    start_job(16'h0010, 16'd4, 16'd2, 16'h0100, 1'b1);
    wait_done(200);
    check_words("basic", 16'h0010, 4, 2, 16'h0100);
    // Issue N+1..N+8, returns N+6..N+13, FIFO head N+7..N+14, done N+15.
    n_checks++;
    if (first_v_cyc !== start_cyc + 7) $display("FAIL basic first_valid: got cycle %0d required %0d", first_v_cyc, start_cyc + 7);
    else n_pass++;
    n_checks++;
    if (done_cyc !== start_cyc + 15) $display("FAIL basic done_time: got cycle %0d required %0d", done_cyc, start_cyc + 15);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || busy_at_done !== 1'b0) $display("FAIL basic busy_after: got %b/%b required 0/0", busy, busy_at_done);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    logic [15:0] lens [2];
    logic [15:0] rows [2];
    lens[0] = 16'd0; rows[0] = 16'd3;
    lens[1] = 16'd5; rows[1] = 16'd0;
    for (int t = 0; t < 2; t++) begin
      start_job(16'h0100, lens[t], rows[t], 16'h0010, 1'b0);
      wait_done(20);
      n_checks++;
      if (rd_q.size() !== 0 || done_cnt !== 1 || done_cyc !== start_cyc + 1 || busy_at_done !== 1'b1)
        $display("FAIL zero_len[%0d]: reads %0d done %0d at %0d busy %b required 0 1 at %0d busy 1",
                 t, rd_q.size(), done_cnt, done_cyc, busy_at_done, start_cyc + 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    start_job(16'h0200, 16'd32, 16'd1, 16'h0000, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (rd_q.size() !== 8 || err_ovf !== 1'b0 || m_valid !== 1'b1 || m_data !== word_of(16'h0200))
      $display("FAIL backpressure_hold: reads %0d ovf %b valid %b data %h required 8 0 1 %h",
               rd_q.size(), err_ovf, m_valid, m_data, word_of(16'h0200));
    else n_pass++;
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(300);
    check_words("backpressure", 16'h0200, 32, 1, 16'h0000);
    n_checks++;
    if (err_ovf !== 1'b0) $display("FAIL backpressure_ovf: got %b required 0", err_ovf);
    else n_pass++;
  endtask

  task automatic test_addr_wrap();
    start_job(16'hFFFE, 16'd4, 16'd1, 16'h0000, 1'b1);
    wait_done(100);
    check_words("addr_wrap", 16'hFFFE, 4, 1, 16'h0000);
  endtask

  task automatic test_reset_mid_job();
    m_ready = 1'b1;
    start_job(16'h0300, 16'd3, 16'd1, 16'h0000, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    @(negedge clk);
    n_checks++;
    if ({busy, done, err_ovf, buf_rd_en, m_valid, m_last, buf_bank_rd_sel} !== 7'b0 || buf_rd_addr !== 16'h0)
      $display("FAIL midreset_state: flags %b addr %h required 0000000 0000",
               {busy, done, err_ovf, buf_rd_en, m_valid, m_last, buf_bank_rd_sel}, buf_rd_addr);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (ret_cnt !== 3 || dq.size() !== 0 || err_ovf !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL midreset_drop: returns %0d words %0d ovf %b valid %b required 3 0 0 0",
               ret_cnt, dq.size(), err_ovf, m_valid);
    else n_pass++;
    start_job(16'h0040, 16'd2, 16'd2, 16'h0010, 1'b0);
    wait_done(100);
    check_words("after_reset", 16'h0040, 2, 2, 16'h0010);
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    start_job(16'h0500, 16'd32, 16'd1, 16'h0000, 1'b0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (err_ovf !== 1'b0) $display("FAIL ovf_before: got %b required 0", err_ovf);
    else n_pass++;
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_ovf !== 1'b1) $display("FAIL ovf_set: got %b required 1", err_ovf);
    else n_pass++;
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(300);
    check_words("ovf_job", 16'h0500, 32, 1, 16'h0000);
    n_checks++;
    if (err_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", err_ovf);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_ovf !== 1'b0) $display("FAIL ovf_clear: got %b required 0", err_ovf);
    else n_pass++;
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_addr_wrap();
    test_reset_mid_job();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
